// File: rtl/find_star_scan_pkg.sv
// Shared geometry, colour and FSM encoding for the star scanner and the top/bottom finder.
package find_star_scan_pkg;

  localparam int unsigned X_SZ      = 3;
  localparam int unsigned Y_SZ      = 3;
  localparam int unsigned WIDTH     = 6;
  localparam int unsigned HEIGHT    = 6;
  localparam int unsigned ADDR_SZ   = 6;
  localparam int unsigned COL_SZ    = 3;
  localparam int unsigned THRESHOLD = 0;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StCheck,
    StFound,
    StAckLow,
    StAckHigh,
    StDone
  } scan_state_e;

endpackage

// File: rtl/find_star_scan_address_translator.sv
// Address translator: maps (x, y) to the linear pixel RAM address y*WIDTH + x.
module find_star_scan_address_translator #(
  parameter int unsigned X_SZ    = find_star_scan_pkg::X_SZ,
  parameter int unsigned Y_SZ    = find_star_scan_pkg::Y_SZ,
  parameter int unsigned ADDR_SZ = find_star_scan_pkg::ADDR_SZ,
  parameter int unsigned WIDTH   = find_star_scan_pkg::WIDTH
) (
  input  logic [X_SZ-1:0]    x,
  input  logic [Y_SZ-1:0]    y,
  output logic [ADDR_SZ-1:0] addr
);

  localparam logic [ADDR_SZ-1:0] WidthBits = ADDR_SZ'(WIDTH);

  logic [ADDR_SZ-1:0] xExt;
  logic [ADDR_SZ-1:0] yExt;
  logic [ADDR_SZ-1:0] rowBase;

  assign xExt = ADDR_SZ'(x);
  assign yExt = ADDR_SZ'(y);

  // WIDTH*y as a sum of shifted copies of y, one per set bit of WIDTH.
  always_comb begin
    rowBase = '0;
    for (int i = 0; i < int'(ADDR_SZ); i++) begin
      if (WidthBits[i]) begin
        rowBase = rowBase + (yExt << i);
      end
    end
  end

  assign addr = rowBase + xExt;

endmodule

// File: rtl/find_star_scan.sv
// Raster scanner: reads the pixel RAM two cycles per pixel and reports every lit pixel,
// pausing on each one until the downstream stage completes a low-then-high handshake.
module find_star_scan #(
  parameter int unsigned X_SZ      = find_star_scan_pkg::X_SZ,
  parameter int unsigned Y_SZ      = find_star_scan_pkg::Y_SZ,
  parameter int unsigned WIDTH     = find_star_scan_pkg::WIDTH,
  parameter int unsigned HEIGHT    = find_star_scan_pkg::HEIGHT,
  parameter int unsigned ADDR_SZ   = find_star_scan_pkg::ADDR_SZ,
  parameter int unsigned COL_SZ    = find_star_scan_pkg::COL_SZ,
  parameter int unsigned THRESHOLD = find_star_scan_pkg::THRESHOLD
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               stageDone,
  input  logic [COL_SZ-1:0]  pixVal,
  output logic [ADDR_SZ-1:0] memAddr,
  output logic [X_SZ-1:0]    starX,
  output logic [Y_SZ-1:0]    starY,
  output logic               starFound,
  output logic               scanning,
  output logic               scanDone
);

  import find_star_scan_pkg::*;

  localparam logic [X_SZ-1:0] LastX = X_SZ'(WIDTH - 1);
  localparam logic [Y_SZ-1:0] LastY = Y_SZ'(HEIGHT - 1);

  scan_state_e        stateQ, stateD;
  logic [X_SZ-1:0]    xQ, xD, nextX;
  logic [Y_SZ-1:0]    yQ, yD, nextY;
  logic [X_SZ-1:0]    starXQ, starXD;
  logic [Y_SZ-1:0]    starYQ, starYD;
  logic [ADDR_SZ-1:0] memAddrQ;
  logic [ADDR_SZ-1:0] pixAddr;
  logic               pixLit;
  logic               lastPix;

  find_star_scan_address_translator #(
    .X_SZ    (X_SZ),
    .Y_SZ    (Y_SZ),
    .ADDR_SZ (ADDR_SZ),
    .WIDTH   (WIDTH)
  ) addrXlat (
    .x    (xQ),
    .y    (yQ),
    .addr (pixAddr)
  );

  assign pixLit  = (pixVal > COL_SZ'(THRESHOLD));
  assign lastPix = (xQ == LastX) && (yQ == LastY);

  // Raster-order successor; only used when the current pixel is not the last one.
  always_comb begin
    nextX = xQ + X_SZ'(1);
    nextY = yQ;
    if (xQ == LastX) begin
      nextX = '0;
      nextY = yQ + Y_SZ'(1);
    end
  end

  always_comb begin
    stateD = stateQ;
    xD     = xQ;
    yD     = yQ;
    starXD = starXQ;
    starYD = starYQ;
    case (stateQ)
      StIdle, StDone: begin
        if (start) begin
          stateD = StIssue;
          xD     = '0;
          yD     = '0;
        end
      end
      StIssue: stateD = StCheck;
      StCheck: begin
        if (pixLit) begin
          stateD = StFound;
          starXD = xQ;
          starYD = yQ;
        end else if (lastPix) begin
          stateD = StDone;
        end else begin
          stateD = StIssue;
          xD     = nextX;
          yD     = nextY;
        end
      end
      StFound: stateD = StAckLow;
      // A level left high by the previous star must drop before it counts again.
      StAckLow: begin
        if (!stageDone) stateD = StAckHigh;
      end
      StAckHigh: begin
        if (stageDone) begin
          if (lastPix) begin
            stateD = StDone;
          end else begin
            stateD = StIssue;
            xD     = nextX;
            yD     = nextY;
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stateQ   <= StIdle;
      xQ       <= '0;
      yQ       <= '0;
      starXQ   <= '0;
      starYQ   <= '0;
      memAddrQ <= '0;
    end else begin
      stateQ   <= stateD;
      xQ       <= xD;
      yQ       <= yD;
      starXQ   <= starXD;
      starYQ   <= starYD;
      memAddrQ <= memAddr;
    end
  end

  // Address is presented combinationally in ISSUE so read data is back during CHECK.
  assign memAddr   = (stateQ == StIssue) ? pixAddr : memAddrQ;
  assign starX     = starXQ;
  assign starY     = starYQ;
  assign starFound = (stateQ == StFound);
  assign scanning  = (stateQ != StIdle) && (stateQ != StDone);
  assign scanDone  = (stateQ == StDone);

endmodule
